// File: rtl/parking_fee_collector.sv
// ---------------------------------------------------------------------------
// parking_fee_collector
//
// Exit-side payment terminal. It latches the fee and slot of a car that is
// checking out, accepts coins until the fee is covered, then pays out change
// and pulses a slot release. Cancel or coin inactivity refunds everything
// inserted and leaves the slot occupied.
//
// Ports:
//   clk            system clock, all state on the rising edge
//   firstInteract  asynchronous active-high reset
//   fee_valid      1-cycle strobe, fee/slot valid
//   fee            amount owed for this checkout
//   slot           slot being checked out, passed through unchecked
//   coin_valid     1-cycle strobe per inserted coin
//   coin_value     value of the inserted coin
//   cancel         user abort, level sampled every clock
//   busy           high whenever a transaction is in progress
//   amount_due     remaining owed, never below zero
//   paid_total     coins accumulated in this transaction
//   change_valid   pulse, change holds change owed after payment
//   refund_valid   pulse, change holds the refunded amount
//   change         change/refund amount, valid with the pulses
//   release_valid  pulse, release_slot may be freed
//   release_slot   slot to free, valid with release_valid
//   fee_reject     pulse, a fee arrived while busy and was ignored
//   coin_reject    pulse, a coin arrived outside collection and is returned
// ---------------------------------------------------------------------------
module parking_fee_collector #(
    parameter int FEE_W   = 11,
    parameter int COIN_W  = 6,
    parameter int TIMEOUT = 1000
) (
    input  logic              clk,
    input  logic              firstInteract,
    input  logic              fee_valid,
    input  logic [FEE_W-1:0]  fee,
    input  logic [3:0]        slot,
    input  logic              coin_valid,
    input  logic [COIN_W-1:0] coin_value,
    input  logic              cancel,
    output logic              busy,
    output logic [FEE_W:0]    amount_due,
    output logic [FEE_W:0]    paid_total,
    output logic              change_valid,
    output logic              refund_valid,
    output logic [FEE_W:0]    change,
    output logic              release_valid,
    output logic [3:0]        release_slot,
    output logic              fee_reject,
    output logic              coin_reject
);

    localparam int PW    = FEE_W + 1;
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_SETTLE,
        S_REFUND
    } state_t;

    state_t             r_state;
    logic [FEE_W-1:0]   r_fee;
    logic [3:0]         r_slot;
    logic [PW-1:0]      r_paid;
    logic [CNT_W-1:0]   r_timer;
    logic               r_changeValid;
    logic               r_refundValid;
    logic [PW-1:0]      r_change;
    logic               r_releaseValid;
    logic [3:0]         r_releaseSlot;
    logic               r_feeReject;
    logic               r_coinReject;

    logic [PW:0]        w_sum;
    logic [PW-1:0]      w_paidNext;
    logic [PW-1:0]      w_feeExt;
    logic               w_complete;
    logic               w_timeoutHit;

    // Running total including this cycle's coin. The extra sum bit catches
    // overflow so the total sticks at all-ones instead of wrapping.
    assign w_sum        = {1'b0, r_paid} + (PW+1)'(coin_value);
    assign w_paidNext   = coin_valid ? (w_sum[PW] ? {PW{1'b1}} : w_sum[PW-1:0]) : r_paid;
    assign w_feeExt     = PW'(r_fee);
    assign w_complete   = (w_paidNext >= w_feeExt);
    assign w_timeoutHit = !coin_valid && (r_timer == CNT_W'(TIMEOUT - 1));

    // amount_due is derived from the latched fee and total; it reads zero in
    // IDLE even though the fee latch keeps its old value between cars.
    assign amount_due    = (r_state != S_IDLE && r_paid < w_feeExt) ? (w_feeExt - r_paid) : '0;
    assign busy          = (r_state != S_IDLE);
    assign paid_total    = r_paid;
    assign change_valid  = r_changeValid;
    assign refund_valid  = r_refundValid;
    assign change        = r_change;
    assign release_valid = r_releaseValid;
    assign release_slot  = r_releaseSlot;
    assign fee_reject    = r_feeReject;
    assign coin_reject   = r_coinReject;

    // Transaction FSM. Every pulse is cleared by default each cycle and set
    // on the edge that enters SETTLE/REFUND, so the pulse lines up with the
    // one-cycle stay in that state. Completion is checked before cancel and
    // timeout so a coin that covers the fee always settles.
    always_ff @(posedge clk or posedge firstInteract) begin
        if (firstInteract) begin
            r_state        <= S_IDLE;
            r_fee          <= '0;
            r_slot         <= '0;
            r_paid         <= '0;
            r_timer        <= '0;
            r_changeValid  <= 1'b0;
            r_refundValid  <= 1'b0;
            r_change       <= '0;
            r_releaseValid <= 1'b0;
            r_releaseSlot  <= '0;
            r_feeReject    <= 1'b0;
            r_coinReject   <= 1'b0;
        end else begin
            r_changeValid  <= 1'b0;
            r_refundValid  <= 1'b0;
            r_change       <= '0;
            r_releaseValid <= 1'b0;
            r_releaseSlot  <= '0;
            r_feeReject    <= fee_valid && (r_state != S_IDLE);
            r_coinReject   <= coin_valid && (r_state != S_COLLECT);

            case (r_state)
                S_IDLE: begin
                    if (fee_valid) begin
                        r_fee   <= fee;
                        r_slot  <= slot;
                        r_paid  <= '0;
                        r_timer <= '0;
                        if (fee != '0) begin
                            r_state <= S_COLLECT;
                        end else begin
                            r_state        <= S_SETTLE;
                            r_changeValid  <= 1'b1;
                            r_releaseValid <= 1'b1;
                            r_releaseSlot  <= slot;
                        end
                    end
                end

                S_COLLECT: begin
                    r_paid  <= w_paidNext;
                    r_timer <= coin_valid ? '0 : (r_timer + 1'b1);
                    if (w_complete) begin
                        r_state        <= S_SETTLE;
                        r_changeValid  <= 1'b1;
                        r_change       <= w_paidNext - w_feeExt;
                        r_releaseValid <= 1'b1;
                        r_releaseSlot  <= r_slot;
                    end else if (cancel || w_timeoutHit) begin
                        r_state       <= S_REFUND;
                        r_refundValid <= 1'b1;
                        r_change      <= w_paidNext;
                    end
                end

                S_SETTLE, S_REFUND: begin
                    r_state <= S_IDLE;
                    r_paid  <= '0;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_parking_fee_collector.sv
// ---------------------------------------------------------------------------
// tb_parking_fee_collector
//
// Drives whole checkout transactions (fee, coin plan, ending) into the fee
// collector. A transaction-level reference predicts each pulse the terminal
// should emit and queues it; an independent monitor pops and compares on
// every cycle in which the DUT shows any pulse.
// ---------------------------------------------------------------------------
module tb_parking_fee_collector;

    localparam int FEE_W   = 11;
    localparam int COIN_W  = 6;
    localparam int TIMEOUT = 8;
    localparam int PW      = FEE_W + 1;
    localparam int PAIDMAX = (1 << PW) - 1;

    logic              clk = 1'b0;
    logic              firstInteract;
    logic              fee_valid;
    logic [FEE_W-1:0]  fee;
    logic [3:0]        slot;
    logic              coin_valid;
    logic [COIN_W-1:0] coin_value;
    logic              cancel;
    logic              busy;
    logic [PW-1:0]     amount_due;
    logic [PW-1:0]     paid_total;
    logic              change_valid;
    logic              refund_valid;
    logic [PW-1:0]     change;
    logic              release_valid;
    logic [3:0]        release_slot;
    logic              fee_reject;
    logic              coin_reject;

    parking_fee_collector #(
        .FEE_W  (FEE_W),
        .COIN_W (COIN_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk          (clk),
        .firstInteract(firstInteract),
        .fee_valid    (fee_valid),
        .fee          (fee),
        .slot         (slot),
        .coin_valid   (coin_valid),
        .coin_value   (coin_value),
        .cancel       (cancel),
        .busy         (busy),
        .amount_due   (amount_due),
        .paid_total   (paid_total),
        .change_valid (change_valid),
        .refund_valid (refund_valid),
        .change       (change),
        .release_valid(release_valid),
        .release_slot (release_slot),
        .fee_reject   (fee_reject),
        .coin_reject  (coin_reject)
    );

    always #5 clk = ~clk;

    // Cycle index used to timestamp expected pulses.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // flags = {change_valid, refund_valid, release_valid, fee_reject, coin_reject}
    typedef struct {
        int         cyc;
        logic [4:0] flags;
        int         chg;
        int         paid;
        int         due;
        int         slot;
        bit         busy;
    } exp_t;

    localparam logic [4:0] EV_SETTLE  = 5'b10100;
    localparam logic [4:0] EV_REFUND  = 5'b01000;
    localparam logic [4:0] EV_FEEREJ  = 5'b00010;
    localparam logic [4:0] EV_COINREJ = 5'b00001;

    exp_t sbQ[$];
    int   planCoin[$];
    int   planGap[$];
    int   checks = 0;
    int   errors = 0;
    int   lastDrv = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic void pushExp(input int c, input logic [4:0] fl, input int chg,
                                    input int paid, input int due, input int sl, input bit b);
        exp_t e;
        e.cyc   = c;
        e.flags = fl;
        e.chg   = chg;
        e.paid  = paid;
        e.due   = due;
        e.slot  = sl;
        e.busy  = b;
        sbQ.push_back(e);
    endfunction

    function automatic int satAdd(input int a, input int b);
        return (a + b > PAIDMAX) ? PAIDMAX : a + b;
    endfunction

    // One input cycle: wait for the falling edge, then present all inputs.
    task automatic drive(input bit fv, input int f, input int s, input bit cv, input int cval, input bit can);
        @(negedge clk);
        fee_valid  = fv;
        fee        = FEE_W'(f);
        slot       = 4'(s);
        coin_valid = cv;
        coin_value = COIN_W'(cval);
        cancel     = can;
        lastDrv    = cyc;
    endtask

    // One checkout. mode: 0 pay, 1 cancel (with coin cancelIdx, or alone
    // after all coins when cancelIdx >= number of coins), 2 walk away.
    task automatic applyStimulus(input int f, input int s, input int mode, input int cancelIdx,
                                 input bit injectFee, input bit coinAfter, input bit coinIdle);
        int paid = 0;
        int run = 0;
        int nDrive;
        int finalCyc;
        bit done = 1'b0;
        bit canWithCoin = 1'b0;
        bit injected = 1'b0;

        // Reference: coins accumulate until the fee is covered; covering the
        // fee wins over a cancel presented with the same coin.
        nDrive = planCoin.size();
        for (int i = 0; i < planCoin.size(); i++) begin
            paid = satAdd(paid, planCoin[i]);
            if (paid >= f) begin
                nDrive = i + 1;
                done   = 1'b1;
                break;
            end
            if (mode == 1 && i == cancelIdx) begin
                nDrive      = i + 1;
                canWithCoin = 1'b1;
                break;
            end
        end

        drive(1'b1, f, s, 1'b0, 0, 1'b0);
        if (f == 0) begin
            finalCyc = lastDrv + 1;
            pushExp(finalCyc, EV_SETTLE, 0, 0, 0, s, 1'b1);
        end else begin
            for (int i = 0; i < nDrive; i++) begin
                for (int g = 0; g < planGap[i]; g++) begin
                    if (injectFee && !injected) begin
                        drive(1'b1, $urandom_range(1, 2047), $urandom_range(0, 15), 1'b0, 0, 1'b0);
                        pushExp(lastDrv + 1, EV_FEEREJ, 0, run, f - run, 0, 1'b1);
                        injected = 1'b1;
                    end else begin
                        drive(1'b0, 0, 0, 1'b0, 0, 1'b0);
                    end
                end
                drive(1'b0, 0, 0, 1'b1, planCoin[i], canWithCoin && (i == nDrive - 1));
                run = satAdd(run, planCoin[i]);
            end
            if (done) begin
                finalCyc = lastDrv + 1;
                pushExp(finalCyc, EV_SETTLE, run - f, run, 0, s, 1'b1);
            end else if (mode == 1) begin
                if (!canWithCoin) drive(1'b0, 0, 0, 1'b0, 0, 1'b1);
                finalCyc = lastDrv + 1;
                pushExp(finalCyc, EV_REFUND, run, run, f - run, 0, 1'b1);
            end else begin
                finalCyc = lastDrv + 1 + TIMEOUT;
                pushExp(finalCyc, EV_REFUND, run, run, f - run, 0, 1'b1);
            end
        end

        while (lastDrv < finalCyc - 1) drive(1'b0, 0, 0, 1'b0, 0, 1'b0);
        if (coinAfter) begin
            drive(1'b0, 0, 0, 1'b1, $urandom_range(1, 63), 1'b0);
            pushExp(lastDrv + 1, EV_COINREJ, 0, 0, 0, 0, 1'b0);
        end
        drive(1'b0, 0, 0, 1'b0, 0, 1'b0);
        drive(1'b0, 0, 0, 1'b0, 0, 1'b0);
        checkOutput("idle_busy", 32'(busy), 0);
        checkOutput("idle_paid_total", 32'(paid_total), 0);
        checkOutput("idle_amount_due", 32'(amount_due), 0);
        if (coinIdle) begin
            drive(1'b0, 0, 0, 1'b1, $urandom_range(1, 63), 1'b0);
            pushExp(lastDrv + 1, EV_COINREJ, 0, 0, 0, 0, 1'b0);
        end
        drive(1'b0, 0, 0, 1'b0, 0, 1'b0);
    endtask

    task automatic setPlan2(input int c0, input int g0, input int c1, input int g1);
        planCoin.delete();
        planGap.delete();
        planCoin.push_back(c0);
        planGap.push_back(g0);
        planCoin.push_back(c1);
        planGap.push_back(g1);
    endtask

    // Scoreboard monitor: any pulse must match the oldest queued prediction.
    always @(negedge clk) begin
        exp_t e;
        if (change_valid || refund_valid || release_valid || fee_reject || coin_reject) begin
            if (sbQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_pulse: got flags %b, expected none (cycle %0d)",
                         {change_valid, refund_valid, release_valid, fee_reject, coin_reject}, cyc);
            end else begin
                e = sbQ.pop_front();
                checkOutput("pulse_cycle", cyc, e.cyc);
                checkOutput("pulse_flags",
                            32'({change_valid, refund_valid, release_valid, fee_reject, coin_reject}),
                            32'(e.flags));
                checkOutput("pulse_paid_total", 32'(paid_total), e.paid);
                checkOutput("pulse_amount_due", 32'(amount_due), e.due);
                checkOutput("pulse_busy", 32'(busy), 32'(e.busy));
                if (e.flags[4] || e.flags[3]) checkOutput("change", 32'(change), e.chg);
                if (e.flags[2]) checkOutput("release_slot", 32'(release_slot), e.slot);
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        firstInteract = 1'b1;
        fee_valid     = 1'b0;
        fee           = '0;
        slot          = '0;
        coin_valid    = 1'b0;
        coin_value    = '0;
        cancel        = 1'b0;
        #2;
        checkOutput("reset_busy", 32'(busy), 0);
        checkOutput("reset_paid_total", 32'(paid_total), 0);
        checkOutput("reset_amount_due", 32'(amount_due), 0);
        checkOutput("reset_change", 32'(change), 0);
        checkOutput("reset_release_slot", 32'(release_slot), 0);
        checkOutput("reset_pulses",
                    32'({change_valid, refund_valid, release_valid, fee_reject, coin_reject}), 0);
        repeat (2) @(negedge clk);
        firstInteract = 1'b0;

        $display("[TB] directed transactions");
        setPlan2(10, 0, 20, 0);  applyStimulus(30, 2, 0, 0, 1'b0, 1'b0, 1'b0);
        setPlan2(20, 1, 20, 0);  applyStimulus(25, 5, 0, 0, 1'b0, 1'b1, 1'b0);
        setPlan2(10, 0, 5, 0);   applyStimulus(50, 1, 1, 1, 1'b0, 1'b0, 1'b0);
        planCoin.delete(); planGap.delete();
        planCoin.push_back(10); planGap.push_back(0);
        applyStimulus(40, 4, 2, 0, 1'b0, 1'b1, 1'b0);
        setPlan2(10, 0, 5, TIMEOUT - 2);
        applyStimulus(40, 4, 2, 0, 1'b0, 1'b0, 1'b0);
        planCoin.delete(); planGap.delete();
        applyStimulus(0, 6, 0, 0, 1'b0, 1'b1, 1'b1);
        setPlan2(30, 2, 40, 0);  applyStimulus(60, 3, 0, 0, 1'b1, 1'b0, 1'b1);
        setPlan2(10, 0, 10, 0);  applyStimulus(20, 7, 1, 1, 1'b0, 1'b0, 1'b0);
        planCoin.delete(); planGap.delete();
        planCoin.push_back(5); planGap.push_back(0);
        applyStimulus(5, 15, 0, 0, 1'b0, 1'b0, 1'b0);
        planCoin.delete(); planGap.delete();
        applyStimulus(9, 0, 1, 0, 1'b0, 1'b0, 1'b0);

        $display("[TB] randomized transactions");
        for (int t = 0; t < 40; t++) begin
            int f;
            int s;
            int mode;
            int sum;
            int c;
            int k;
            planCoin.delete();
            planGap.delete();
            f    = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 250);
            s    = $urandom_range(0, 15);
            mode = $urandom_range(0, 2);
            if (f != 0) begin
                if (mode == 0) begin
                    sum = 0;
                    while (sum < f) begin
                        c = $urandom_range(1, 63);
                        planCoin.push_back(c);
                        planGap.push_back($urandom_range(0, TIMEOUT - 2));
                        sum += c;
                    end
                end else begin
                    k = $urandom_range(0, 4);
                    for (int i = 0; i < k; i++) begin
                        planCoin.push_back($urandom_range(1, 63));
                        planGap.push_back($urandom_range(0, TIMEOUT - 2));
                    end
                end
            end
            applyStimulus(f, s, mode, $urandom_range(0, planCoin.size()),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("[TB] asynchronous reset mid-collection");
        drive(1'b1, 100, 3, 1'b0, 0, 1'b0);
        drive(1'b0, 0, 0, 1'b1, 10, 1'b0);
        drive(1'b0, 0, 0, 1'b1, 10, 1'b0);
        drive(1'b0, 0, 0, 1'b0, 0, 1'b0);
        checkOutput("pre_reset_paid_total", 32'(paid_total), 20);
        checkOutput("pre_reset_amount_due", 32'(amount_due), 80);
        @(posedge clk);
        #2;
        firstInteract = 1'b1;
        #1;
        checkOutput("async_reset_busy", 32'(busy), 0);
        checkOutput("async_reset_paid_total", 32'(paid_total), 0);
        checkOutput("async_reset_amount_due", 32'(amount_due), 0);
        checkOutput("async_reset_pulses",
                    32'({change_valid, refund_valid, release_valid, fee_reject, coin_reject}), 0);
        @(posedge clk);
        @(negedge clk);
        firstInteract = 1'b0;
        repeat (TIMEOUT + 4) drive(1'b0, 0, 0, 1'b0, 0, 1'b0);
        checkOutput("post_reset_busy", 32'(busy), 0);
        checkOutput("post_reset_paid_total", 32'(paid_total), 0);

        repeat (5) drive(1'b0, 0, 0, 1'b0, 0, 1'b0);
        checkOutput("scoreboard_empty", sbQ.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
